mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_ctrl_arb.sv | 16 +
 rtl/mem_controller.sv | 200 ++++++++++++++++++++
 tb/tb_mem_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_pkg;

  // Controller phases: only IDLE accepts new requests.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // LSB access width codes.
  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  // addr[17:16] value that marks the memory-mapped I/O window.
  localparam logic [1:0] IO_ADDR_HI_DEFAULT = 2'b11;

  // Index of the last byte of an access (N-1); the unused code 3 behaves as a word.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] width);
    logic [1:0] idx;
    case (width)
      WIDTH_BYTE: idx = 2'd0;
      WIDTH_HALF: idx = 2'd1;
      WIDTH_WORD: idx = 2'd3;
      default:    idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Fixed-priority grant between the load/store buffer and instruction fetch.
module mem_ctrl_arb (
  input  logic accept_ok,
  input  logic if_req,
  input  logic lsb_req,
  output logic grant_if,
  output logic grant_lsb
);

  // LSB always wins; nothing is granted unless the controller can accept.
  always_comb begin
    grant_lsb = accept_ok & lsb_req;
    grant_if  = accept_ok & if_req & ~lsb_req;
  end

endmodule

// File: rtl/mem_controller.sv
// Byte-serial RAM controller serving fetch and LSB requests, with I/O write back-pressure.
module mem_controller
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_ADDR_HI = IO_ADDR_HI_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  if_query_en,
  input  logic [ADDR_WIDTH-1:0] if_query_addr,
  output logic                  if_reply_en,
  output logic [31:0]           if_reply_data,
  input  logic                  lsb_query_en,
  input  logic                  lsb_query_type,
  input  logic [ADDR_WIDTH-1:0] lsb_query_addr,
  input  logic [1:0]            lsb_data_width,
  input  logic [31:0]           lsb_query_data,
  output logic                  lsb_reply_en,
  output logic [31:0]           lsb_reply_data,
  input  logic                  flush_signal
);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            last_q, last_d;
  logic                  is_lsb_q, is_lsb_d;
  logic                  is_wr_q, is_wr_d;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  accept_ok, grant_if, grant_lsb;
  logic [ADDR_WIDTH-1:0] next_a;
  logic [31:0]           reply_word;

  // A write byte to the I/O window must wait while the UART buffer is full.
  function automatic logic io_stall(input logic [ADDR_WIDTH-1:0] a, input logic full);
    return (a[17:16] == IO_ADDR_HI) && full;
  endfunction

  assign accept_ok = rdy_in && (state_q == ST_IDLE) && !flush_signal;
  assign next_a    = mem_a_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  mem_ctrl_arb u_arb (
    .accept_ok (accept_ok),
    .if_req    (if_query_en),
    .lsb_req   (lsb_query_en),
    .grant_if  (grant_if),
    .grant_lsb (grant_lsb)
  );

  // Next-state: accept, walk bytes, capture read data, stall I/O writes, honour flush.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    is_lsb_d   = is_lsb_q;
    is_wr_d    = is_wr_q;
    data_d     = data_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          if (grant_lsb) begin
            is_lsb_d = 1'b1;
            is_wr_d  = lsb_query_type;
            cnt_d    = 2'd0;
            last_d   = last_byte_idx(lsb_data_width);
            mem_a_d  = lsb_query_addr;
            if (lsb_query_type) begin
              state_d    = ST_WRITE;
              data_d     = lsb_query_data;
              mem_dout_d = lsb_query_data[7:0];
              mem_wr_d   = !io_stall(lsb_query_addr, io_buffer_full);
            end else begin
              state_d = ST_READ;
              data_d  = 32'd0;
            end
          end else if (grant_if) begin
            is_lsb_d = 1'b0;
            is_wr_d  = 1'b0;
            cnt_d    = 2'd0;
            last_d   = 2'd3;
            mem_a_d  = if_query_addr;
            state_d  = ST_READ;
            data_d   = 32'd0;
          end else begin
            mem_wr_d = 1'b0;
          end
        end
        ST_READ: begin
          if (flush_signal) begin
            state_d = ST_IDLE;
          end else begin
            // mem_din now carries the byte addressed one cycle ago.
            if (cnt_q != 2'd0) begin
              data_d[{cnt_q - 2'd1, 3'b000} +: 8] = mem_din;
            end
            if (cnt_q == last_q) begin
              state_d = ST_DONE;
            end else begin
              cnt_d   = cnt_q + 2'd1;
              mem_a_d = next_a;
            end
          end
        end
        ST_WRITE: begin
          if (mem_wr_q) begin
            if (cnt_q == last_q) begin
              state_d  = ST_DONE;
              mem_wr_d = 1'b0;
            end else begin
              cnt_d      = cnt_q + 2'd1;
              mem_a_d    = next_a;
              mem_dout_d = data_q[{cnt_q + 2'd1, 3'b000} +: 8];
              mem_wr_d   = !io_stall(next_a, io_buffer_full);
            end
          end else begin
            mem_wr_d = !io_stall(mem_a_q, io_buffer_full);
          end
        end
        ST_DONE: begin
          state_d  = ST_IDLE;
          mem_wr_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          mem_wr_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset discards any access in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      last_q     <= 2'd0;
      is_lsb_q   <= 1'b0;
      is_wr_q    <= 1'b0;
      data_q     <= 32'd0;
      mem_a_q    <= {ADDR_WIDTH{1'b0}};
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      is_lsb_q   <= is_lsb_d;
      is_wr_q    <= is_wr_d;
      data_q     <= data_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  // Reply during DONE; the last read byte arrives on mem_din in that same cycle.
  always_comb begin
    if_reply_en    = 1'b0;
    lsb_reply_en   = 1'b0;
    if_reply_data  = 32'd0;
    lsb_reply_data = 32'd0;
    reply_word     = data_q;
    reply_word[{last_q, 3'b000} +: 8] = mem_din;
    if (state_q == ST_DONE) begin
      if (is_wr_q) begin
        reply_word = 32'd0;
      end else begin
        reply_word = reply_word;
      end
      if (is_lsb_q) begin
        lsb_reply_en   = 1'b1;
        lsb_reply_data = reply_word;
      end else begin
        if_reply_en    = 1'b1;
        if_reply_data  = reply_word;
      end
    end else begin
      reply_word = 32'd0;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_controller.sv
// Randomized bench for mem_controller with a transaction-level timing/data model.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        rst_n, rdy_in, mem_wr, io_buffer_full, flush_signal;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        if_query_en, if_reply_en, lsb_query_en, lsb_query_type, lsb_reply_en;
  logic [31:0] if_query_addr, if_reply_data, lsb_query_addr, lsb_query_data, lsb_reply_data;
  logic [1:0]  lsb_data_width;

  always #5 clk = ~clk;

  mem_controller #(.ADDR_WIDTH(32), .IO_ADDR_HI(2'b11)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_query_en(if_query_en), .if_query_addr(if_query_addr),
    .if_reply_en(if_reply_en), .if_reply_data(if_reply_data),
    .lsb_query_en(lsb_query_en), .lsb_query_type(lsb_query_type),
    .lsb_query_addr(lsb_query_addr), .lsb_data_width(lsb_data_width),
    .lsb_query_data(lsb_query_data), .lsb_reply_en(lsb_reply_en),
    .lsb_reply_data(lsb_reply_data), .flush_signal(flush_signal)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] ram  [logic [31:0]];   // device RAM driven by the DUT
  logic [7:0] refm [logic [31:0]];   // model's view of memory contents

  logic        exp_on = 1'b0;
  logic [31:0] exp_a, exp_data;
  logic        exp_wr, exp_if, exp_lsb;
  logic [7:0]  exp_dout;
  logic [31:0] last_a;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_on = 1'b1; exp_a = last_a; exp_wr = 1'b0; exp_if = 1'b0; exp_lsb = 1'b0;
  endtask

  // RAM: read data appears the cycle after its address; writes land on the edge.
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  // Compare DUT outputs against the model expectation every cycle.
  always @(negedge clk) begin
    if (exp_on) begin
      chk("mem_a", mem_a, exp_a);
      chk("mem_wr", {31'd0, mem_wr}, {31'd0, exp_wr});
      if (exp_wr) chk("mem_dout", {24'd0, mem_dout}, {24'd0, exp_dout});
      chk("if_reply_en", {31'd0, if_reply_en}, {31'd0, exp_if});
      chk("lsb_reply_en", {31'd0, lsb_reply_en}, {31'd0, exp_lsb});
      if (exp_if)  chk("if_reply_data", if_reply_data, exp_data);
      if (exp_lsb) chk("lsb_reply_data", lsb_reply_data, exp_data);
    end
  end

  // One transaction, called during an idle cycle at posedge+1; returns at the next idle cycle.
  task automatic run_txn(input bit lsb, input bit wr, input logic [31:0] addr,
                         input logic [1:0] w, input logic [31:0] wdata, input int flush_at,
                         input logic [31:0] fullmask, input bit idle_flush, input int freeze_at,
                         output int rep_cyc, output logic [31:0] rep_data);
    int n, k;
    logic [31:0] rd_exp, ba;
    bit stalled, mfull;
    n = (!lsb) ? 4 : (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    rd_exp = 32'd0;
    for (int i = 0; i < n; i++) rd_exp[8*i +: 8] = ref_rd(addr + i);
    rep_cyc = -1; rep_data = 32'd0; k = 0;
    set_idle();
    if (lsb) begin
      lsb_query_en = 1'b1; lsb_query_type = wr; lsb_query_addr = addr;
      lsb_data_width = w; lsb_query_data = wdata;
    end else begin
      if_query_en = 1'b1; if_query_addr = addr;
    end
    io_buffer_full = fullmask[0];
    if (idle_flush) begin
      flush_signal = 1'b1;
      step();
      set_idle();
      flush_signal = 1'b0;
    end
    for (int j = 1; j <= 64; j++) begin
      step();
      if (!wr) begin
        io_buffer_full = 1'b0;
        if (j <= n) begin
          exp_a = addr + j - 1; exp_wr = 1'b0; exp_if = 1'b0; exp_lsb = 1'b0;
          if (j == flush_at) begin
            flush_signal = 1'b1;
            if (lsb) lsb_query_en = 1'b0; else if_query_en = 1'b0;
            step();
            flush_signal = 1'b0;
            last_a = addr + j - 1;
            set_idle();
            return;
          end
        end else begin
          exp_a = addr + n - 1; exp_wr = 1'b0; exp_if = !lsb; exp_lsb = lsb; exp_data = rd_exp;
          rep_cyc = j;
          rep_data = lsb ? lsb_reply_data : if_reply_data;
          flush_signal = (j == flush_at);
          if (lsb) lsb_query_en = 1'b0; else if_query_en = 1'b0;
          step();
          flush_signal = 1'b0;
          last_a = addr + n - 1;
          set_idle();
          return;
        end
      end else begin
        if (k == n) begin
          exp_a = addr + n - 1; exp_wr = 1'b0; exp_lsb = 1'b1; exp_if = 1'b0; exp_data = 32'd0;
          rep_cyc = j;
          rep_data = lsb_reply_data;
          lsb_query_en = 1'b0;
          step();
          flush_signal = 1'b0;
          io_buffer_full = 1'b0;
          last_a = addr + n - 1;
          set_idle();
          return;
        end
        ba = addr + k;
        mfull = fullmask[j-1];
        stalled = (ba[17:16] == 2'b11) && mfull;
        exp_a = ba; exp_wr = !stalled; exp_dout = wdata[8*k +: 8]; exp_if = 1'b0; exp_lsb = 1'b0;
        if (!stalled) begin
          refm[ba] = wdata[8*k +: 8];
          k++;
        end
        io_buffer_full = (j < 32) ? fullmask[j] : 1'b0;
        flush_signal = (j == flush_at);
        if (j == freeze_at) begin
          rdy_in = 1'b0;
          step();
          step();
          rdy_in = 1'b1;
        end
      end
    end
    chk("txn_timeout", 32'd1, 32'd0);
  endtask

  int          rc, kind, fa, fz, n;
  logic [31:0] rdat, a, d, fm;
  logic [1:0]  w;
  bit          idf;

  initial begin
    rst_n = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush_signal = 1'b0;
    if_query_en = 1'b0; if_query_addr = 32'd0;
    lsb_query_en = 1'b0; lsb_query_type = 1'b0; lsb_query_addr = 32'd0;
    lsb_data_width = 2'd0; lsb_query_data = 32'd0;
    last_a = 32'd0;
    for (int b = 0; b < 4; b++) begin
      logic [31:0] base;
      case (b)
        0: base = 32'h0000_0000;
        1: base = 32'h0000_0100;
        2: base = 32'h0003_FFF0;
        default: base = 32'hFFFF_FFF8;
      endcase
      for (int i = 0; i < 32; i++) begin
        logic [7:0] v;
        v = 8'($urandom());
        ram[base + i] = v;
        refm[base + i] = v;
      end
    end
    #2;
    chk("reset_mem_a", mem_a, 32'd0);
    chk("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("reset_lsb_reply_en", {31'd0, lsb_reply_en}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    set_idle();
    step();

    // lw 0x100 with known bytes
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    refm[32'h100] = 8'h11; refm[32'h101] = 8'h22; refm[32'h102] = 8'h33; refm[32'h103] = 8'h44;
    run_txn(1'b1, 1'b0, 32'h100, 2'd2, 32'd0, 0, 32'd0, 1'b0, 0, rc, rdat);
    chk("lw_reply_cycle", 32'(rc), 32'd5);
    chk("lw_data", rdat, 32'h4433_2211);

    // sb and fetch together: LSB first, fetch after DONE
    if_query_en = 1'b1; if_query_addr = 32'h100;
    run_txn(1'b1, 1'b1, 32'h20, 2'd0, 32'h0000_00AB, 0, 32'd0, 1'b0, 0, rc, rdat);
    chk("sb_reply_cycle", 32'(rc), 32'd2);
    chk("sb_ram_byte", {24'd0, ram_rd(32'h20)}, 32'h0000_00AB);
    run_txn(1'b0, 1'b0, 32'h100, 2'd2, 32'd0, 0, 32'd0, 1'b0, 0, rc, rdat);
    chk("fetch_after_sb_cycle", 32'(rc), 32'd5);
    chk("fetch_after_sb_data", rdat, 32'h4433_2211);

    // lh 0x2
    run_txn(1'b1, 1'b0, 32'h2, 2'd1, 32'd0, 0, 32'd0, 1'b0, 0, rc, rdat);
    chk("lh_reply_cycle", 32'(rc), 32'd3);
    chk("lh_upper_zero", {16'd0, rdat[31:16]}, 32'd0);

    // fetch aborted by flush; store ignores the same flush
    run_txn(1'b0, 1'b0, 32'h8, 2'd2, 32'd0, 2, 32'd0, 1'b0, 0, rc, rdat);
    chk("flush_fetch_no_reply", 32'(rc), 32'hFFFF_FFFF);
    run_txn(1'b1, 1'b1, 32'h40, 2'd2, 32'hCAFE_F00D, 2, 32'd0, 1'b0, 0, rc, rdat);
    chk("flush_sw_reply_cycle", 32'(rc), 32'd5);

    // I/O store with buffer full for three cycles
    run_txn(1'b1, 1'b1, 32'h3_0000, 2'd0, 32'h0000_005A, 0, 32'h7, 1'b0, 0, rc, rdat);
    chk("io_sb_reply_cycle", 32'(rc), 32'd5);
    chk("io_sb_ram_byte", {24'd0, ram_rd(32'h3_0000)}, 32'h0000_005A);

    // flush blocking acceptance in IDLE, plus a rdy_in freeze mid-store
    run_txn(1'b1, 1'b1, 32'h60, 2'd2, 32'h1234_5678, 0, 32'd0, 1'b1, 2, rc, rdat);
    chk("freeze_sw_reply_cycle", 32'(rc), 32'd5);

    // word read crossing the top of the address space
    run_txn(1'b1, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'd0, 0, 32'd0, 1'b0, 0, rc, rdat);
    chk("wrap_lw_cycle", 32'(rc), 32'd5);

    // randomized mix
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: a = 32'h0000_0000;
        1: a = 32'h0000_0100;
        2: a = 32'h0003_FFF0;
        default: a = 32'hFFFF_FFF8;
      endcase
      a = a + 32'($urandom_range(0, 15));
      w = 2'($urandom_range(0, 3));
      n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      idf = ($urandom_range(0, 7) == 0);
      if (kind == 0) begin
        fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
        run_txn(1'b0, 1'b0, a, 2'd2, 32'd0, fa, 32'd0, idf, 0, rc, rdat);
      end else if (kind == 1) begin
        fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 1) : 0;
        run_txn(1'b1, 1'b0, a, w, 32'd0, fa, 32'd0, idf, 0, rc, rdat);
      end else begin
        d  = $urandom();
        fm = ($urandom_range(0, 1) == 1) ? $urandom() : 32'd0;
        fa = $urandom_range(0, 6);
        fz = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        run_txn(1'b1, 1'b1, a, w, d, fa, fm, idf, fz, rc, rdat);
      end
    end

    // reset in the middle of a word read
    set_idle();
    lsb_query_en = 1'b1; lsb_query_type = 1'b0; lsb_data_width = 2'd2; lsb_query_addr = 32'h104;
    step();
    exp_on = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_a", mem_a, 32'd0);
    chk("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mid_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_mid_lsb_reply_en", {31'd0, lsb_reply_en}, 32'd0);
    chk("rst_mid_lsb_reply_data", lsb_reply_data, 32'd0);
    lsb_query_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    last_a = 32'd0;
    set_idle();
    repeat (8) step();
    exp_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
